// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencing controller with memory wait timeout
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ALUOp,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ImmSrc,
  output logic [3:0]            state,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [WW-1:0]  wait_q;
  logic [6:0]     op;
  logic [2:0]     funct3;
  logic           mem_phase;
  logic           stall;
  logic           wait_hit;
  logic           set_illegal;
  logic           unused_instr_bits;

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign state    = state_q;
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:15], instr[11:7]};

  // The three memory-facing states are the only ones that can stall.
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign stall     = mem_phase && !mem_ready;
  assign wait_hit  = stall && (wait_q == WW'(MAX_WAIT - 1));

  // Immediate format follows the opcode alone so sign_extend is ready in any state.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                   ImmSrc = 3'b001;
      OP_BRANCH:                  ImmSrc = 3'b010;
      OP_JAL:                     ImmSrc = 3'b011;
      OP_LUI:                     ImmSrc = 3'b100;
      default:                    ImmSrc = 3'b000;
    endcase
  end

  // Datapath control decode and next-state selection.
  always_comb begin
    state_d     = state_q;
    mem_req     = mem_phase;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ResultSrc   = 2'b00;
    set_illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d     = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        state_d = S_FETCH;
        case (funct3)
          3'b000:  PCWrite = EQ;
          3'b001:  PCWrite = !EQ;
          default: begin
            state_d     = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // A stall that exhausts the budget overrides the normal successor.
    if (wait_hit) state_d = S_TRAP;
    // PC and IR must not load while the core is held in reset.
    IRWrite = IRWrite && rst_n;
    PCWrite = PCWrite && rst_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Consecutive stall counter, restarted whenever the state moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_q <= '0;
    else if (state_d != state_q) wait_q <= '0;
    else if (stall)              wait_q <= wait_q + WW'(1);
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      illegal <= illegal || set_illegal;
      timeout <= timeout || wait_hit;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized and directed checks of multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        EQ = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  state;
  logic        illegal, timeout;

  int n_chk = 0;
  int n_err = 0;

  multicycle_ctrl #(.DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .state(state),
    .illegal(illegal), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  // ---------------- instruction-level reference model ----------------
  int   m_state = 0;
  int   m_stalls = 0;
  logic m_ill = 1'b0;
  logic m_to = 1'b0;
  int   plan[$];

  task automatic model_reset();
    m_state = 0; m_stalls = 0; m_ill = 1'b0; m_to = 1'b0; plan.delete();
  endtask

  // Route an instruction takes after leaving fetch.
  task automatic build_plan(input logic [6:0] op);
    plan.delete();
    case (op)
      7'b0000011: plan = '{1, 2, 3, 4};
      7'b0100011: plan = '{1, 2, 5};
      7'b0110011: plan = '{1, 6, 8};
      7'b0010011: plan = '{1, 7, 8};
      7'b1100011: plan = '{1, 9};
      7'b1101111: plan = '{1, 10, 8};
      7'b1100111: plan = '{1, 11, 10, 8};
      7'b0110111: plan = '{1, 12, 8};
      default:    plan = '{1, 15};
    endcase
  endtask

  task automatic model_step();
    if (m_state == 15) return;
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_stalls = m_stalls + 1;
      if (m_stalls >= MW) begin
        m_state = 15; m_to = 1'b1; m_stalls = 0; plan.delete();
      end
      return;
    end
    m_stalls = 0;
    if (m_state == 0) build_plan(instr[6:0]);
    if (m_state == 9 && instr[14:12] > 3'd1) begin
      m_state = 15; m_ill = 1'b1; plan.delete();
      return;
    end
    if (plan.size() == 0) m_state = 0;
    else                  m_state = plan.pop_front();
    if (m_state == 15) m_ill = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  function automatic logic [22:0] exp_vec(input int st, input logic [31:0] ins, input logic eq,
                                          input logic mr, input logic rn, input logic ill, input logic to);
    logic mreq, adr, irw, pcw, mw, rw;
    logic [1:0] a, b, alu, rs;
    logic [2:0] imm;
    mreq = 0; adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0;
    a = 0; b = 0; alu = 0; rs = 0; imm = 0;
    case (st)
      0:  begin mreq = 1; b = 2; rs = 2; irw = mr; pcw = mr; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin mreq = 1; adr = 1; mw = 1; end
      6:  begin a = 2; alu = 2; end
      7:  begin a = 2; b = 1; alu = 2; end
      8:  begin rw = 1; end
      9:  begin a = 2; alu = 1; pcw = (ins[14:12] == 3'd0) ? eq : (ins[14:12] == 3'd1) ? !eq : 1'b0; end
      10: begin a = 1; b = 2; pcw = 1; end
      11: begin a = 2; b = 1; end
      12: begin a = 3; b = 1; end
      default: ;
    endcase
    case (ins[6:0])
      7'b0100011: imm = 3'd1;
      7'b1100011: imm = 3'd2;
      7'b1101111: imm = 3'd3;
      7'b0110111: imm = 3'd4;
      default:    imm = 3'd0;
    endcase
    irw = irw & rn;
    pcw = pcw & rn;
    return {mreq, adr, irw, pcw, mw, rw, a, b, alu, rs, imm, ill, to, 4'(st)};
  endfunction

  // Every cycle: DUT outputs against the model, sampled mid low phase.
  initial forever begin
    logic [22:0] act, exp;
    @(negedge clk); #2;
    act = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
           ALUOp, ResultSrc, ImmSrc, illegal, timeout, state};
    exp = exp_vec(m_state, instr, EQ, mem_ready, rst_n, m_ill, m_to);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle_compare t=%0t instr=%h got=%h expected=%h", $time, instr, act, exp);
    end
  end

  // ---------------- directed helpers ----------------
  logic [63:0] st_tr, ab_tr;
  logic [15:0] rw_tr, pw_tr, ir_tr, adr_tr, mw_tr;

  task automatic clr();
    st_tr = 0; ab_tr = 0; rw_tr = 0; pw_tr = 0; ir_tr = 0; adr_tr = 0; mw_tr = 0;
  endtask

  task automatic cyc(input logic mr, input logic eq);
    @(negedge clk);
    mem_ready = mr; EQ = eq;
    #2;
    st_tr  = {st_tr[59:0], state};
    ab_tr  = {ab_tr[59:0], ALUSrcA, ALUSrcB};
    rw_tr  = {rw_tr[14:0], RegWrite};
    pw_tr  = {pw_tr[14:0], PCWrite};
    ir_tr  = {ir_tr[14:0], IRWrite};
    adr_tr = {adr_tr[14:0], AdrSrc};
    mw_tr  = {mw_tr[14:0], MemWrite};
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 19);
    case (k)
      0, 1:      r[6:0] = 7'b0000011;
      2, 3:      r[6:0] = 7'b0100011;
      4, 5:      r[6:0] = 7'b0110011;
      6, 7:      r[6:0] = 7'b0010011;
      8, 9, 10:  r[6:0] = 7'b1100011;
      11, 12:    r[6:0] = 7'b1101111;
      13, 14:    r[6:0] = 7'b1100111;
      15, 16:    r[6:0] = 7'b0110111;
      default:   ;
    endcase
    if (r[6:0] == 7'b1100011 && $urandom_range(0, 3) != 0) r[14:12] = 3'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int trap_cyc;

    // Reset state, with mem_ready high to show IR/PC loads are suppressed.
    rst_n = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_state", state, 0);
    chk("reset_outputs", {mem_req, IRWrite, PCWrite, ALUSrcB, ResultSrc, illegal, timeout}, 9'b1_0_0_10_10_0_0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add
    instr = 32'h002081B3; clr();
    cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
    chk("add_states", st_tr[19:0], 20'h01680);
    chk("add_regwrite", rw_tr[4:0], 5'b00010);
    chk("add_pcwrite", pw_tr[4:0], 5'b10000);
    chk("add_irwrite", ir_tr[4:0], 5'b10000);

    // lw with three wait cycles in MEMREAD
    instr = 32'h0000A103; clr();
    cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
    chk("lw_states", st_tr[35:0], 36'h012333340);
    chk("lw_adrsrc", adr_tr[8:0], 9'b000111100);
    chk("lw_regwrite", rw_tr[8:0], 9'b000000010);

    // beq taken and not taken
    instr = 32'h00208463; clr();
    cyc(1, 0); cyc(0, 0); cyc(0, 1); cyc(0, 0);
    chk("beq_taken_states", st_tr[15:0], 16'h0190);
    chk("beq_taken_pcwrite", pw_tr[3:0], 4'b1010);
    clr();
    cyc(1, 1); cyc(0, 1); cyc(0, 0); cyc(0, 1);
    chk("beq_not_taken_pcwrite", pw_tr[3:0], 4'b1000);

    // jalr
    instr = 32'h000080E7; clr();
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0);
    chk("jalr_states", st_tr[23:0], 24'h01BA80);
    chk("jalr_pcwrite", pw_tr[5:0], 6'b100100);
    chk("jalr_alusrc", ab_tr[23:0], 24'h259602);

    // illegal opcode parks in TRAP
    instr = 32'h0000007F; clr();
    cyc(1, 0); cyc(0, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (state != 4'd15 || !illegal || mem_req || IRWrite || PCWrite || MemWrite || RegWrite) bad++;
    end
    chk("illegal_trap_cycles_bad", bad, 0);
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #2;
    chk("illegal_reset_clear", {state, illegal}, 5'b0000_0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fetch stall timeout
    instr = 32'h00000013; clr();
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0);
    chk("timeout_states", st_tr[19:0], 20'h0000F);
    chk("timeout_irwrite", ir_tr[4:0], 5'b00000);
    chk("timeout_flag", timeout, 1);
    reset_pulse();

    // sw, reset asserted while MemWrite is held
    instr = 32'h0020A023; clr();
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
    chk("sw_states", st_tr[19:0], 20'h01255);
    chk("sw_memwrite", mw_tr[4:0], 5'b00011);
    #1 rst_n = 1'b0;
    #1 chk("sw_async_reset", {MemWrite, state}, 5'b0_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized run
    trap_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_state == 15) trap_cyc++;
      if (!rst_n) rst_n = 1'b1;
      else if (trap_cyc > 3 || $urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        trap_cyc = 0;
      end
      if (m_state == 0) instr = rand_instr();
      mem_ready = ($urandom_range(0, 3) != 0);
      EQ = 1'($urandom_range(0, 1));
    end

    @(negedge clk); #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Sequencing controller for the multi-cycle RV32I core.
- Walks each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath mux selects and write strobes every cycle.
- Handshakes with the shared instruction/data memory and times out stalled accesses.
- Sits between the instruction register and the existing ALU decoder (driven via ALUOp) and `sign_extend` (driven via ImmSrc).

## Interface

Parameters:
- DATA_WIDTH, 32, instruction width
- MAX_WAIT, 255, maximum consecutive stalled memory cycles before trap (≥1, counter width $clog2(MAX_WAIT+1))

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  DATA_WIDTH  IR contents; op=instr[6:0], funct3=instr[14:12]
- EQ  in  1  ALU equality flag, sampled in BRANCH
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- IRWrite  out  1  load IR (and OldPC) from memory read data
- PCWrite  out  1  load PC from result bus
- MemWrite  out  1  store strobe
- RegWrite  out  1  register-file write strobe
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 (A reg), 11=zero
- ALUSrcB  out  2  00=rs2 (B reg), 01=ImmExt, 10=constant 4
- ALUOp  out  2  00=add, 01=subtract/compare, 10=funct-decoded
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALUResult
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- state  out  4  current state, debug
- illegal  out  1  sticky: unsupported opcode/funct3
- timeout  out  1  sticky: memory stall exceeded MAX_WAIT

## Operation

State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, TRAP=15.

- Outputs are combinational decode of state, op, funct3, EQ and mem_ready. Unlisted outputs are 0.
- ImmSrc depends on op only, independent of state:
  - load, op-imm, jalr → I
  - store → S
  - branch → B
  - jal → J
  - lui → U
  - otherwise 000

State behaviour:
- FETCH: mem_req=1, AdrSrc=0, A=00, B=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are asserted only when mem_ready=1. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: A=01, B=01, ALUOp=00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other op → TRAP with illegal=1
- MEMADR: A=10, B=01, ALUOp=00. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, held for the whole wait. Goes to FETCH on mem_ready.
- EXECR: A=10, B=00, ALUOp=10, then ALUWB.
- EXECI: A=10, B=01, ALUOp=10, then ALUWB.
- LUI: A=11, B=01, ALUOp=00, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, then FETCH.
  - funct3=000: PCWrite=EQ.
  - funct3=001: PCWrite=!EQ.
  - Any other funct3 → TRAP with illegal=1 and PCWrite=0.
- JALR: A=10, B=01, ALUOp=00 (rs1+imm into ALUOut), then JAL.
- JAL: A=01, B=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB (rd ← OldPC+4).
- TRAP: all strobes and mem_req are 0. Stays in TRAP until reset.

Wait counter:
- Increments each cycle that mem_req=1 and mem_ready=0.
- Clears on any state change.
- Reaching MAX_WAIT while still stalled → TRAP with timeout=1 next cycle, and no strobe fires.

## Timing

- Reset (rst_n low, asynchronous) sets:
  - state=FETCH, wait counter=0, illegal=0, timeout=0.
  - Outputs then show FETCH decode: mem_req=1, ALUSrcB=10, ResultSrc=10, all else 0.
  - IRWrite/PCWrite are additionally forced 0 while rst_n=0.
- Reset mid-instruction abandons it immediately, with no partial writeback.
- Cycles per instruction with zero-wait memory (mem_ready tied 1):
  - branch: 3
  - R-type, I-type, sw, jal, lui: 4
  - lw, jalr: 5
- Each wait cycle adds 1, in FETCH, MEMREAD or MEMWRITE only.
- mem_ready is ignored in states with mem_req=0.
- Strobes are single-cycle, except MemWrite, which is held across the wait.
- All state transitions occur on the rising edge of clk.

## Test plan

- Reset then mem_ready=1, instr=0x002081B3 (add): states 0,1,6,8,0. RegWrite high only in cycle 4. PCWrite/IRWrite high in cycle 1.
- lw 0x0000A103 with mem_ready low for 3 cycles in MEMREAD: MEMREAD held 4 cycles with AdrSrc=1. MEMWB follows with ResultSrc=01, RegWrite=1. Total 8 cycles.
- Branch 0x00208463 (beq): EQ=1 gives PCWrite=1 in BRANCH. EQ=0 gives PCWrite=0. Both return to FETCH after 3 cycles.
- jalr 0x000080E7: sequence 0,1,11,10,8,0. PCWrite in JAL with ALUSrcA=01, ALUSrcB=10.
- Illegal op 0x0000007F: DECODE → TRAP. illegal=1 and all strobes 0 for 20 cycles. rst_n low clears to FETCH.
- MAX_WAIT=4 with mem_ready held low in FETCH: TRAP after 4 stalled cycles, timeout=1, IRWrite never asserted. Assert rst_n low during MEMWRITE of a separate run: MemWrite drops to 0 asynchronously.
